wiring_input_debounce: RTL and testbench
========================================

# wiring_input_debounce

Four-channel input conditioner that feeds the four-input OR gate network. Each raw, asynchronous channel passes through a two-flop synchronizer, then a stability filter. A channel's clean level updates only after the synchronized input has differed from it for `STABLE_CYCLES` consecutive cycles. The block presents glitch-free levels `a`, `b`, `c`, `d` downstream, plus a change pulse and a settled flag.

## Interface
- `STABLE_CYCLES`, default 4: consecutive mismatch cycles required to accept a new level; legal range 1..255.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `raw_a`, `raw_b`, `raw_c`, `raw_d` input 1 each: unsynchronized channel inputs.
- `a`, `b`, `c`, `d` output 1 each: debounced levels; reset 0.
- `changed` output 1: one-cycle pulse, high in the cycle after any channel output updates; reset 0.
- `settled` output 1: high when no channel has a pending mismatch; reset 1.
- `glitch_count` output 8: only with `DEBOUNCE_GLITCH_CNT_EN`; saturating count of rejected glitches; reset 0.

## Operation
- Per channel, registers:
  - sync stage `s1`, `s2`, both reset 0;
  - counter `cnt`, 8 bits, reset 0;
  - output level `q`, reset 0.
- Each edge:
  - `s1 <= raw`.
  - `s2 <= s1`.
- Filter rule, evaluated on `s2` vs `q`:
  - `s2 == q`: `cnt <= 0`. If `cnt != 0` at that point, this is a rejected glitch (pending change abandoned).
  - `s2 != q` and `cnt == STABLE_CYCLES-1`: `q <= s2`, `cnt <= 0`.
  - `s2 != q` otherwise: `cnt <= cnt+1`.
- No intermediate state beyond `cnt`; the per-channel "state machine" has two effective states:
  - IDLE (`cnt == 0`, `s2 == q`);
  - PENDING (mismatch being counted).
  - PENDING returns to IDLE on acceptance or on the input reverting.
- `changed`:
  - registered OR of all four "accept" conditions;
  - multiple channels accepting on the same edge yield one pulse.
- `settled`:
  - combinational AND of (`cnt == 0` and `s2 == q`) over all channels;
  - low whenever any channel is PENDING or has a fresh mismatch at `s2`.
- Channels are fully independent; no cross-channel priority.
- `STABLE_CYCLES = 1`:
  - a mismatch is accepted on its first cycle;
  - `cnt` stays 0;
  - no glitches are ever counted.

## Timing
- Raw transition captured at edge E0 (setup met): `s2` changes at E1, and `q` changes at edge E1+`STABLE_CYCLES`.
  - Total latency: `STABLE_CYCLES`+2 rising edges, counting E0.
  - Default (4): `q` changes 5 edges after E0.
- `changed` is high for the single cycle following the edge at which `q` changed.
- Glitch rejection:
  - A raw pulse is rejected if its synchronized width is ≤ `STABLE_CYCLES`-1 cycles.
  - A pulse of exactly `STABLE_CYCLES` cycles is accepted.
- Input reverting on the same edge that would reach the threshold: compare uses current `s2`. If `s2 == q`, there is no acceptance, and a glitch is counted.
- `rst_n` low at any time clears all registers immediately to reset values, regardless of `clk`. Pending counts are discarded, not completed.
- Release of `rst_n` is synchronous to `clk` at system level. The first capture occurs at the first edge after release.

## Configuration
- `DEBOUNCE_GLITCH_CNT_EN` defined:
  - adds the `glitch_count` port and an 8-bit counter;
  - per edge, adds the number (0..4) of channels rejecting a glitch;
  - saturates at 255 with no wrap;
  - cleared only by `rst_n`.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then hold all `raw_*` = 0 for 20 cycles: `a..d` = 0, `changed` = 0, `settled` = 1 throughout; `glitch_count` = 0.
- `raw_a` 0→1, held with `STABLE_CYCLES` = 4: `a` rises exactly 5 edges after capture; `changed` high exactly 1 cycle; `settled` low from E1 until `a` updates.
- `raw_b` 3-cycle high pulse, default: `b` stays 0; `glitch_count` = 1. A 4-cycle pulse: `b` goes 1 for 4 cycles, then returns 0 after the same latency.
- `raw_c` and `raw_d` toggled on the same edge: `c` and `d` update on the same edge; exactly one `changed` pulse.
- 300 two-cycle glitches on all four channels simultaneously: `glitch_count` advances by 4 per glitch, then saturates at 255.
- `rst_n` asserted mid-count (`cnt` = 2 on `raw_a`): `a`, `cnt`, `changed`, `glitch_count` clear immediately, without waiting for an edge. After release with `raw_a` still 1, the full latency restarts from the first edge.

Source files
------------

// File: rtl/wiring_input_debounce.sv
// Four-channel input conditioner: two-flop synchronizer plus stability filter per channel.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_count output.
module wiring_input_debounce #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_c,
  input  logic       raw_d,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       changed,
  output logic       settled
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam int unsigned NCH      = 4;
  localparam logic [7:0]  LAST_CNT = 8'(STABLE_CYCLES - 1);

  logic [NCH-1:0] raw_vec;
  logic [NCH-1:0] lvl_vec;
  logic [NCH-1:0] accept_vec;
  logic [NCH-1:0] idle_vec;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [NCH-1:0] glitch_vec;
`endif

  assign raw_vec = {raw_d, raw_c, raw_b, raw_a};

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic       s1_q;
      logic       s2_q;
      logic       lvl_q;
      logic       lvl_d;
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;
      logic       mismatch;

      assign mismatch        = s2_q ^ lvl_q;
      assign accept_vec[gi]  = mismatch && (cnt_q == LAST_CNT);
      assign idle_vec[gi]    = !mismatch && (cnt_q == 8'd0);
      assign lvl_vec[gi]     = lvl_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      // Input returned to the current level while a change was still being counted.
      assign glitch_vec[gi]  = !mismatch && (cnt_q != 8'd0);
`endif

      always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (!mismatch) begin
          cnt_d = 8'd0;
        end else if (accept_vec[gi]) begin
          lvl_d = s2_q;
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          lvl_q <= 1'b0;
          cnt_q <= 8'd0;
        end else begin
          s1_q  <= raw_vec[gi];
          s2_q  <= s1_q;
          lvl_q <= lvl_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  logic changed_q;
  logic changed_d;

  // Simultaneous acceptances on several channels collapse into one pulse.
  assign changed_d = |accept_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;
  assign settled = &idle_vec;
  assign a       = lvl_vec[0];
  assign b       = lvl_vec[1];
  assign c       = lvl_vec[2];
  assign d       = lvl_vec[3];

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gcnt_q;
  logic [7:0] gcnt_d;
  logic [2:0] glitch_sum;
  logic [8:0] gcnt_sum;

  always_comb begin
    glitch_sum = 3'd0;
    for (int i = 0; i < NCH; i++) begin
      glitch_sum = glitch_sum + {2'b00, glitch_vec[i]};
    end
    gcnt_sum = {1'b0, gcnt_q} + {6'd0, glitch_sum};
    gcnt_d   = gcnt_sum[8] ? 8'hFF : gcnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q <= 8'd0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_count = gcnt_q;
`endif

endmodule

// File: tb/tb_wiring_input_debounce.sv
// Scoreboard bench for wiring_input_debounce: a window-based reference model pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_wiring_input_debounce;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic raw_c = 1'b0;
  logic raw_d = 1'b0;
  logic a, b, c, d, changed, settled;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wiring_input_debounce #(.STABLE_CYCLES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .raw_c   (raw_c),
    .raw_d   (raw_d),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .changed (changed),
    .settled (settled)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_count (glitch_count)
`endif
  );

  typedef struct packed {
    logic [3:0] lvl;
    logic       chg;
    logic       stl;
    logic [7:0] gc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: history of synchronized samples (raw delayed by two edges).
  // A channel accepts when its last N samples all differ from its output level.
  logic [3:0] m_hist[$];
  logic [3:0] m_s1;
  logic [3:0] m_q;
  logic [7:0] m_gc;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i <= N; i++) m_hist.push_back(4'b0000);
    m_s1 = 4'b0000;
    m_q  = 4'b0000;
    m_gc = 8'd0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    exp_t       e;
    logic [3:0] cur, prev, acc;
    int         ng;
    bit         all_diff;
    if (!rst_n) begin
      model_reset();
      e = '{lvl: 4'b0000, chg: 1'b0, stl: 1'b1, gc: 8'd0};
    end else begin
      cur = m_hist[$];
      prev = m_hist[$-1];
      acc = 4'b0000;
      ng = 0;
      for (int ch = 0; ch < 4; ch++) begin
        all_diff = 1'b1;
        for (int k = 0; k < N; k++)
          if (m_hist[m_hist.size()-1-k][ch] == m_q[ch]) all_diff = 1'b0;
        acc[ch] = all_diff;
        if (cur[ch] == m_q[ch] && prev[ch] != m_q[ch]) ng++;
      end
      m_q = m_q ^ acc;
      if (int'(m_gc) + ng > 255) m_gc = 8'hFF;
      else m_gc = 8'(int'(m_gc) + ng);
      m_hist.push_back(m_s1);
      m_s1 = {raw_d, raw_c, raw_b, raw_a};
      if (m_hist.size() > 64) void'(m_hist.pop_front());
      e.lvl = m_q;
      e.chg = |acc;
      e.stl = (m_hist[$] == m_q) && (m_hist[$-1] == m_q);
      e.gc  = m_gc;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      // An asynchronous reset since the last edge overrides the queued expectation.
      if (!rst_n) e = '{lvl: 4'b0000, chg: 1'b0, stl: 1'b1, gc: 8'd0};
      chk("levels", {28'd0, d, c, b, a}, {28'd0, e.lvl});
      chk("changed", {31'd0, changed}, {31'd0, e.chg});
      chk("settled", {31'd0, settled}, {31'd0, e.stl});
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("glitch_count", {24'd0, glitch_count}, {24'd0, e.gc});
`endif
    end
  end

  task automatic drive(input logic [3:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      {raw_d, raw_c, raw_b, raw_a} = v;
    end
  endtask

  // Edges from the first capture edge until a rises (0 if it never does).
  task automatic measure_a_latency(output int lat);
    lat = 0;
    for (int k = 1; k <= N + 8; k++) begin
      @(posedge clk);
      #1;
      if (a === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, pulses;
    logic [3:0] v, mask;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 20);
    $display("txn idle_hold cycles=20");

    drive(4'b0001, 1);
    measure_a_latency(lat);
    chk("a_rise_latency", lat, N + 2);
    drive(4'b0001, 5);
    drive(4'b0000, 10);
    $display("txn a_step latency=%0d", lat);

    drive(4'b0010, 3);
    drive(4'b0000, 10);
    chk("b_short_pulse_rejected", {31'd0, b}, 32'd0);
    drive(4'b0010, 4);
    drive(4'b0000, 12);
    $display("txn b_pulses widths=3,4");

    drive(4'b1100, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (changed === 1'b1) pulses++;
    end
    chk("cd_single_changed_pulse", pulses, 1);
    chk("cd_levels", {30'd0, d, c}, 32'd3);
    drive(4'b0000, 12);
    $display("txn cd_same_edge pulses=%0d", pulses);

    for (int g = 0; g < 300; g++) begin
      drive(4'b1111, 2);
      drive(4'b0000, 2);
    end
    drive(4'b0000, 6);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_saturated", {24'd0, glitch_count}, 32'd255);
`endif
    chk("glitch_levels_quiet", {28'd0, d, c, b, a}, 32'd0);
    $display("txn glitch_burst count=300");

    drive(4'b0001, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("pending_not_settled", {31'd0, settled}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", {31'd0, a}, 32'd0);
    chk("async_rst_changed", {31'd0, changed}, 32'd0);
    chk("async_rst_settled", {31'd0, settled}, 32'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("async_rst_glitch_count", {24'd0, glitch_count}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure_a_latency(lat);
    chk("a_latency_after_reset", lat, N + 2);
    drive(4'b0000, 10);
    $display("txn reset_mid_count relatency=%0d", lat);

    v = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      for (int ch = 0; ch < 4; ch++) mask[ch] = ($urandom_range(0, 3) == 0);
      v = v ^ mask;
      drive(v, 1);
    end
    drive(4'b0000, 12);
    $display("txn random cycles=2000");

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
